// File: rtl/fsm_proc_pkg.sv
// Shared encodings for the FSM processor control path.
// Sequencer top states and default phase names.
package fsm_proc_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_RUN    = 2'd1,
    SEQ_HALTED = 2'd2
  } seq_state_e;

  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_EXEC   = 2;
  localparam int PH_WB     = 3;

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the decoder and the phase sequencer.
// master drives requests, slave is the sequencer.
interface phase_sequencer_if #(
  parameter int NUM_PHASES = 4,
  parameter int COUNT_W    = 16
);
  localparam int IDX_W = $clog2(NUM_PHASES);

  logic                  start;
  logic                  stall;
  logic                  halt_req;
  logic [NUM_PHASES-1:0] skip;
  logic [NUM_PHASES-1:0] phase_onehot;
  logic [IDX_W-1:0]      phase_idx;
  logic                  instr_done;
  logic [COUNT_W-1:0]    instr_count;
  logic                  busy;
  logic                  halted;

  modport master (
    output start, stall, halt_req, skip,
    input  phase_onehot, phase_idx,
    input  instr_done, instr_count,
    input  busy, halted
  );

  modport slave (
    input  start, stall, halt_req, skip,
    output phase_onehot, phase_idx,
    output instr_done, instr_count,
    output busy, halted
  );

endinterface

// File: rtl/phase_sequencer_next_sel.sv
// Masked priority search: lowest unskipped phase above the current one.
// wrap=1 when no such phase exists; nxt then points at phase 0.
module phase_next_sel #(
  parameter int NUM_PHASES = 4
) (
  input  logic [NUM_PHASES-1:0] cur,
  input  logic [NUM_PHASES-1:0] skip,
  output logic [NUM_PHASES-1:0] nxt,
  output logic                  wrap
);

  logic seen;

  always_comb begin
    nxt  = '0;
    wrap = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (wrap && seen && !skip[i]) begin
        nxt[i] = 1'b1;
        wrap   = 1'b0;
      end
      seen = seen | cur[i];
    end
    if (wrap) nxt = NUM_PHASES'(1);
  end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction-phase sequencer: one-hot phase stepping with skip,
// stall, start/halt control and a retired-instruction counter.
module phase_sequencer
  import fsm_proc_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int COUNT_W    = 16
) (
  input logic clk,
  input logic rst,
  phase_sequencer_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_PHASES);
  localparam logic [NUM_PHASES-1:0] PH0 =
    NUM_PHASES'(1) << PH_FETCH;

  seq_state_e            state_q, state_d;
  logic [NUM_PHASES-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  done_q, done_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic                  pend_q, pend_d;
  logic                  busy_q, halted_q;

  logic [NUM_PHASES-1:0] nxt;
  logic                  wrap;

  phase_next_sel #(
    .NUM_PHASES(NUM_PHASES)
  ) u_next (
    .cur  (phase_q),
    .skip (bus.skip),
    .nxt  (nxt),
    .wrap (wrap)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    done_d  = 1'b0;
    count_d = count_q;
    pend_d  = pend_q;
    unique case (state_q)
      SEQ_IDLE, SEQ_HALTED: begin
        if (bus.start) begin
          state_d = SEQ_RUN;
          phase_d = PH0;
        end
      end
      SEQ_RUN: begin
        pend_d = pend_q | bus.halt_req;
        if (!bus.stall) begin
          if (wrap) begin
            done_d  = 1'b1;
            count_d = count_q + COUNT_W'(1);
            if (pend_q | bus.halt_req) begin
              state_d = SEQ_HALTED;
              phase_d = '0;
              pend_d  = 1'b0;
            end else begin
              phase_d = PH0;
            end
          end else begin
            phase_d = nxt;
          end
        end
      end
      default: begin
        state_d = SEQ_IDLE;
        phase_d = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  // Index is registered alongside the phase so both change together.
  always_comb begin
    idx_d = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (phase_d[i]) idx_d = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SEQ_IDLE;
      phase_q  <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      count_q  <= '0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      busy_q   <= (state_d == SEQ_RUN);
      halted_q <= (state_d == SEQ_HALTED);
    end
  end

  assign bus.phase_onehot = phase_q;
  assign bus.phase_idx    = idx_q;
  assign bus.instr_done   = done_q;
  assign bus.instr_count  = count_q;
  assign bus.busy         = busy_q;
  assign bus.halted       = halted_q;

endmodule
